// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the ID-stage controller: opcodes, ALU commands,
// branch conditions and the MULT sequencing FSM state type.
package multicycle_controller_pkg;

  // Opcode codes (instruction bits [31:26])
  localparam int unsigned OP_ADD  = 1;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_SLL  = 11;
  localparam int unsigned OP_ADDI = 32;
  localparam int unsigned OP_LD   = 36;
  localparam int unsigned OP_ST   = 37;
  localparam int unsigned OP_BNE  = 41;
  localparam int unsigned OP_JMP  = 42;
  localparam int unsigned OP_MULT = 50;

  // ALU commands; the bubble value doubles as "no operation"
  localparam int unsigned EXE_NO_OPERATION = 0;
  localparam int unsigned EXE_ADD          = 1;
  localparam int unsigned EXE_SUB          = 2;
  localparam int unsigned EXE_AND          = 3;
  localparam int unsigned EXE_SLL          = 4;
  localparam int unsigned EXE_MULT         = 5;

  // Branch conditions
  localparam int unsigned COND_NONE = 0;
  localparam int unsigned COND_JUMP = 1;
  localparam int unsigned COND_BNE  = 2;

  // MULT sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MBUSY = 2'd1,
    MWB   = 2'd2
  } mc_state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Pure combinational opcode to control-bundle map. Flags unknown opcodes
// and marks MULT so the controller can start its multi-cycle sequence.
module opcode_decoder
  import multicycle_controller_pkg::*;
#(
  parameter int OP_CODE_LEN = 6,
  parameter int EXE_CMD_LEN = 4
) (
  input  logic [OP_CODE_LEN-1:0] op_code,
  output logic                   branch_en,
  output logic                   is_imm,
  output logic                   st_or_bne,
  output logic                   wb_en,
  output logic                   mem_r_en,
  output logic                   mem_w_en,
  output logic [EXE_CMD_LEN-1:0] exe_cmd,
  output logic [1:0]             branch_command,
  output logic                   is_mult,
  output logic                   illegal_op
);

  // Opcode lookup; anything not listed is illegal with all control low
  always_comb begin
    branch_en      = 1'b0;
    is_imm         = 1'b0;
    st_or_bne      = 1'b0;
    wb_en          = 1'b0;
    mem_r_en       = 1'b0;
    mem_w_en       = 1'b0;
    exe_cmd        = '0;
    branch_command = '0;
    is_mult        = 1'b0;
    illegal_op     = 1'b0;
    case (op_code)
      OP_CODE_LEN'(OP_ADD): begin
        exe_cmd = EXE_CMD_LEN'(EXE_ADD);
        wb_en   = 1'b1;
      end
      OP_CODE_LEN'(OP_SUB): begin
        exe_cmd = EXE_CMD_LEN'(EXE_SUB);
        wb_en   = 1'b1;
      end
      OP_CODE_LEN'(OP_AND): begin
        exe_cmd = EXE_CMD_LEN'(EXE_AND);
        wb_en   = 1'b1;
      end
      OP_CODE_LEN'(OP_SLL): begin
        exe_cmd = EXE_CMD_LEN'(EXE_SLL);
        wb_en   = 1'b1;
      end
      OP_CODE_LEN'(OP_ADDI): begin
        exe_cmd = EXE_CMD_LEN'(EXE_ADD);
        wb_en   = 1'b1;
        is_imm  = 1'b1;
      end
      OP_CODE_LEN'(OP_LD): begin
        exe_cmd   = EXE_CMD_LEN'(EXE_ADD);
        wb_en     = 1'b1;
        is_imm    = 1'b1;
        st_or_bne = 1'b1;
        mem_r_en  = 1'b1;
      end
      OP_CODE_LEN'(OP_ST): begin
        exe_cmd   = EXE_CMD_LEN'(EXE_ADD);
        is_imm    = 1'b1;
        st_or_bne = 1'b1;
        mem_w_en  = 1'b1;
      end
      OP_CODE_LEN'(OP_BNE): begin
        exe_cmd        = EXE_CMD_LEN'(EXE_NO_OPERATION);
        is_imm         = 1'b1;
        branch_command = 2'(COND_BNE);
        branch_en      = 1'b1;
        st_or_bne      = 1'b1;
      end
      OP_CODE_LEN'(OP_JMP): begin
        exe_cmd        = EXE_CMD_LEN'(EXE_NO_OPERATION);
        is_imm         = 1'b1;
        branch_command = 2'(COND_JUMP);
        branch_en      = 1'b1;
      end
      OP_CODE_LEN'(OP_MULT): begin
        exe_cmd = EXE_CMD_LEN'(EXE_MULT);
        is_mult = 1'b1;
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// ID-stage controller: single-cycle decode plus a small FSM that sequences
// a multi-cycle MULT (start, stall for the latency, then a write-back slot).
// Outputs are combinational from state, counter and inputs so single-cycle
// ops keep zero decode latency.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OP_CODE_LEN = 6,
  parameter int EXE_CMD_LEN = 4,
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_CODE_LEN-1:0] opCode,
  input  logic                   instr_valid,
  input  logic                   hazard_detected,
  input  logic                   flush,
  output logic                   branchEn,
  output logic                   Is_Imm,
  output logic                   ST_or_BNE,
  output logic                   WB_EN,
  output logic                   MEM_R_EN,
  output logic                   MEM_W_EN,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [1:0]             Branch_command,
  output logic                   mult_start,
  output logic                   mult_wb,
  output logic                   mult_abort,
  output logic                   stall_req,
  output logic                   illegal_op
);

  mc_state_t              state;
  logic [CNT_W-1:0]       cnt;

  logic                   dec_branch_en;
  logic                   dec_is_imm;
  logic                   dec_st_or_bne;
  logic                   dec_wb_en;
  logic                   dec_mem_r_en;
  logic                   dec_mem_w_en;
  logic [EXE_CMD_LEN-1:0] dec_exe_cmd;
  logic [1:0]             dec_branch_command;
  logic                   dec_is_mult;
  logic                   dec_illegal_op;
  logic                   id_live;

  opcode_decoder #(
    .OP_CODE_LEN (OP_CODE_LEN),
    .EXE_CMD_LEN (EXE_CMD_LEN)
  ) u_opcode_decoder (
    .op_code        (opCode),
    .branch_en      (dec_branch_en),
    .is_imm         (dec_is_imm),
    .st_or_bne      (dec_st_or_bne),
    .wb_en          (dec_wb_en),
    .mem_r_en       (dec_mem_r_en),
    .mem_w_en       (dec_mem_w_en),
    .exe_cmd        (dec_exe_cmd),
    .branch_command (dec_branch_command),
    .is_mult        (dec_is_mult),
    .illegal_op     (dec_illegal_op)
  );

  // ID carries a real, non-bubbled instruction this cycle
  assign id_live = instr_valid && !hazard_detected && !flush;

  // FSM state and latency counter; MBUSY leaves at cnt==1 so no wrap occurs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (id_live && dec_is_mult) begin
            state <= MBUSY;
            cnt   <= CNT_W'(MULT_CYCLES - 1);
          end
        end
        MBUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= MWB;
            end
          end
        end
        MWB: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output mux; rst is folded in so outputs drop the instant reset asserts
  always_comb begin
    branchEn       = 1'b0;
    Is_Imm         = 1'b0;
    ST_or_BNE      = 1'b0;
    WB_EN          = 1'b0;
    MEM_R_EN       = 1'b0;
    MEM_W_EN       = 1'b0;
    EXE_CMD        = '0;
    Branch_command = '0;
    mult_start     = 1'b0;
    mult_wb        = 1'b0;
    mult_abort     = 1'b0;
    stall_req      = 1'b0;
    illegal_op     = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (id_live) begin
            branchEn       = dec_branch_en;
            Is_Imm         = dec_is_imm;
            ST_or_BNE      = dec_st_or_bne;
            WB_EN          = dec_wb_en;
            MEM_R_EN       = dec_mem_r_en;
            MEM_W_EN       = dec_mem_w_en;
            EXE_CMD        = dec_exe_cmd;
            Branch_command = dec_branch_command;
            mult_start     = dec_is_mult;
            stall_req      = dec_is_mult;
            illegal_op     = dec_illegal_op;
          end
        end
        MBUSY: begin
          if (flush) begin
            mult_abort = 1'b1;
          end else begin
            stall_req = 1'b1;
          end
        end
        MWB: begin
          if (flush) begin
            mult_abort = 1'b1;
          end else begin
            mult_wb = 1'b1;
            WB_EN   = 1'b1;
            EXE_CMD = EXE_CMD_LEN'(EXE_MULT);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model
// that tracks MULT occupancy as "cycles since issue".
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int M = 4;

  typedef struct packed {
    logic       br;
    logic       imm;
    logic       sob;
    logic       wb;
    logic       mr;
    logic       mw;
    logic [3:0] exe;
    logic [1:0] bc;
    logic       ms;
    logic       mwb;
    logic       ma;
    logic       st;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opCode = '0;
  logic       instr_valid = 1'b0;
  logic       hazard_detected = 1'b0;
  logic       flush = 1'b0;
  logic       branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN;
  logic [3:0] EXE_CMD;
  logic [1:0] Branch_command;
  logic       mult_start, mult_wb, mult_abort, stall_req, illegal_op;
  ctl_t       got;

  int checks = 0;
  int errors = 0;
  int age = -1;       // cycles since MULT issue, -1 when no MULT in flight
  int next_age = -1;

  always #5 clk = ~clk;

  multicycle_controller #(
    .OP_CODE_LEN (6),
    .EXE_CMD_LEN (4),
    .MULT_CYCLES (M),
    .CNT_W       (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .opCode          (opCode),
    .instr_valid     (instr_valid),
    .hazard_detected (hazard_detected),
    .flush           (flush),
    .branchEn        (branchEn),
    .Is_Imm          (Is_Imm),
    .ST_or_BNE       (ST_or_BNE),
    .WB_EN           (WB_EN),
    .MEM_R_EN        (MEM_R_EN),
    .MEM_W_EN        (MEM_W_EN),
    .EXE_CMD         (EXE_CMD),
    .Branch_command  (Branch_command),
    .mult_start      (mult_start),
    .mult_wb         (mult_wb),
    .mult_abort      (mult_abort),
    .stall_req       (stall_req),
    .illegal_op      (illegal_op)
  );

  assign got = {branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN,
                EXE_CMD, Branch_command, mult_start, mult_wb, mult_abort,
                stall_req, illegal_op};

  function automatic ctl_t decode_ref(input logic [5:0] op);
    ctl_t c = '0;
    case (op)
      6'(OP_ADD):  begin c.exe = 4'(EXE_ADD); c.wb = 1'b1; end
      6'(OP_SUB):  begin c.exe = 4'(EXE_SUB); c.wb = 1'b1; end
      6'(OP_AND):  begin c.exe = 4'(EXE_AND); c.wb = 1'b1; end
      6'(OP_SLL):  begin c.exe = 4'(EXE_SLL); c.wb = 1'b1; end
      6'(OP_ADDI): begin c.exe = 4'(EXE_ADD); c.wb = 1'b1; c.imm = 1'b1; end
      6'(OP_LD):   begin c.exe = 4'(EXE_ADD); c.wb = 1'b1; c.imm = 1'b1;
                         c.sob = 1'b1; c.mr = 1'b1; end
      6'(OP_ST):   begin c.exe = 4'(EXE_ADD); c.imm = 1'b1; c.sob = 1'b1;
                         c.mw = 1'b1; end
      6'(OP_BNE):  begin c.imm = 1'b1; c.bc = 2'(COND_BNE); c.br = 1'b1;
                         c.sob = 1'b1; end
      6'(OP_JMP):  begin c.imm = 1'b1; c.bc = 2'(COND_JUMP); c.br = 1'b1; end
      6'(OP_MULT): begin c.exe = 4'(EXE_MULT); c.ms = 1'b1; c.st = 1'b1; end
      default:     c.ill = 1'b1;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: advance the model, drive inputs, compare mid-cycle
  task automatic step(input logic r, input logic v, input logic h,
                      input logic f, input logic [5:0] op);
    ctl_t exp;
    @(posedge clk);
    age = next_age;
    #1;
    rst = r; instr_valid = v; hazard_detected = h; flush = f; opCode = op;
    exp = '0;
    next_age = -1;
    if (!r) begin
      age = -1;
    end else if (age >= 1) begin
      if (f) begin
        exp.ma = 1'b1;
      end else if (age < M) begin
        exp.st = 1'b1;
        next_age = age + 1;
      end else begin
        exp.mwb = 1'b1;
        exp.wb  = 1'b1;
        exp.exe = 4'(EXE_MULT);
      end
    end else if (v && !h && !f) begin
      exp = decode_ref(op);
      if (op == 6'(OP_MULT)) next_age = 1;
    end
    @(negedge clk);
    check("model", 32'(got), 32'(exp));
  endtask

  initial begin
    logic [5:0] legal [10];
    legal = '{6'(OP_ADD), 6'(OP_SUB), 6'(OP_AND), 6'(OP_SLL), 6'(OP_ADDI),
              6'(OP_LD), 6'(OP_ST), 6'(OP_BNE), 6'(OP_JMP), 6'(OP_MULT)};

    // Reset: all outputs zero even with a live instruction presented
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'(OP_ADD));
    check("reset_zero", 32'(got), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 6'(OP_MULT));

    // Zero-latency ADD decode
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_ADD));
    check("add_exe", 32'(EXE_CMD), 32'd1);
    check("add_wb", 32'(WB_EN), 32'd1);
    check("add_stall", 32'(stall_req), 32'd0);
    check("add_ill", 32'(illegal_op), 32'd0);

    // MULT: start at 0, stall 0..3, write-back at 4, decode again at 5
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_MULT));
    check("mul_start", 32'({mult_start, stall_req, WB_EN}), 32'b110);
    for (int i = 1; i < M; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_ADD));
      check("mul_busy", 32'({mult_start, stall_req, WB_EN, mult_wb}), 32'b0100);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_ADD));
    check("mul_wb", 32'({mult_wb, WB_EN, stall_req}), 32'b110);
    check("mul_wb_exe", 32'(EXE_CMD), 32'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_SUB));
    check("mul_after", 32'({mult_wb, EXE_CMD}), 32'h02);

    // MULT flushed at cycle 2: abort, no write-back, ADD decodes at 3
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_MULT));
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'(OP_ADD));
    step(1'b1, 1'b1, 1'b0, 1'b1, 6'(OP_ADD));
    check("flush_abort", 32'({mult_abort, stall_req, mult_wb}), 32'b100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_ADD));
    check("flush_add", 32'({EXE_CMD, WB_EN, mult_wb}), 32'b0001_1_0);
    for (int i = 4; i <= 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_AND));
      check("flush_no_wb", 32'(mult_wb), 32'd0);
    end

    // Hazard and flush+hazard bubbles
    step(1'b1, 1'b1, 1'b1, 1'b0, 6'(OP_LD));
    check("hazard_ld", 32'(got), 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 6'(OP_LD));
    check("flush_hazard", 32'(got), 32'h0);

    // Unknown opcode, valid and not valid
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'd63);
    check("illegal", 32'(got), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd63);
    check("illegal_invalid", 32'(got), 32'h0);

    // Reset during MBUSY with counter at 2
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_MULT));
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    rst = 1'b0;
    #1;
    check("rst_async", 32'(got), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 6'(OP_ADD));
    check("rst_add", 32'({EXE_CMD, WB_EN, mult_wb, stall_req}), 32'b0001_1_0_0);
    for (int i = 0; i < M + 1; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      check("rst_no_wb", 32'(mult_wb), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [5:0] op;
      logic r, v, h, f;
      op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 9)]
                                        : 6'($urandom);
      r  = ($urandom_range(0, 79) != 0);
      v  = ($urandom_range(0, 9) != 0);
      h  = ($urandom_range(0, 9) == 0);
      f  = ($urandom_range(0, 14) == 0);
      step(r, v, h, f, op);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised successor to the single-cycle ID-stage decoder. It decodes the opcode into EX/MEM/WB control and sequences multi-cycle MULT through a small FSM with a latency counter. While the multiplier runs it requests a front-end stall, then issues the MULT write-back that the single-cycle decoder never produced. It sits in the ID stage, driving the ID/EX register and the IF/ID freeze logic.

## Interface
- OP_CODE_LEN, 6, opcode width
- EXE_CMD_LEN, 4, ALU command width
- MULT_CYCLES, 4, multiplier latency in cycles, legal range 2..15
- CNT_W, 4, counter width, must satisfy 2^CNT_W > MULT_CYCLES
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- opCode  in  OP_CODE_LEN  opcode of the instruction in ID
- instr_valid  in  1  ID holds a real instruction
- hazard_detected  in  1  data hazard; ID must issue a bubble
- flush  in  1  taken branch/jump in EX; kill ID and any MULT in flight
- branchEn, Is_Imm, ST_or_BNE, WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  control to ID/EX
- EXE_CMD  out  EXE_CMD_LEN  ALU command
- Branch_command  out  2  branch condition
- mult_start  out  1  one-cycle pulse, launches the multiplier
- mult_wb  out  1  one-cycle pulse, MULT result write-back slot
- mult_abort  out  1  one-cycle pulse, MULT cancelled by flush
- stall_req  out  1  freeze PC and IF/ID
- illegal_op  out  1  valid instruction with an unknown opcode

## Operation
- FSM states: IDLE, MBUSY, MWB. State and counter are registered. All outputs are combinational from the state, counter and inputs.
- While rst is low: state is IDLE, counter is 0, and every output is forced to 0.
- IDLE, with priority flush > hazard_detected > !instr_valid > decode:
  - flush, hazard_detected or !instr_valid: all outputs 0 (bubble).
  - Otherwise decode as follows:
    - ADD, SUB, AND, SLL: matching EXE_CMD, WB_EN=1.
    - ADDI: EXE_ADD, WB_EN=1, Is_Imm=1.
    - LD: EXE_ADD, WB_EN=1, Is_Imm=1, ST_or_BNE=1, MEM_R_EN=1.
    - ST: EXE_ADD, Is_Imm=1, ST_or_BNE=1, MEM_W_EN=1.
    - BNE: EXE_NO_OPERATION, Is_Imm=1, COND_BNE, branchEn=1, ST_or_BNE=1.
    - JMP: EXE_NO_OPERATION, Is_Imm=1, COND_JUMP, branchEn=1.
    - MULT: EXE_MULT, WB_EN=0, mult_start=1, stall_req=1. Next state MBUSY, counter loads MULT_CYCLES-1.
    - Any other opcode: all outputs 0, illegal_op=1.
- MBUSY:
  - Outputs: stall_req=1, all other outputs 0.
  - Counter decrements each cycle. At counter==1 the next state is MWB.
  - inputs hazard_detected, instr_valid and opCode are ignored.
- MWB:
  - Outputs: mult_wb=1, WB_EN=1, EXE_CMD=EXE_MULT, stall_req=0.
  - Next state IDLE. The instruction now in ID is decoded in the following cycle.
- Flush in MBUSY or MWB: all outputs 0, mult_abort=1, next state IDLE, counter cleared. No mult_wb is issued.

## Timing
- Single-cycle ops: control is valid in the same cycle as opCode, zero latency.
- MULT is issued at cycle t:
  - cycles t .. t+MULT_CYCLES-1: stall_req=1.
  - cycle t+MULT_CYCLES: mult_wb.
  - Total occupancy is MULT_CYCLES+1 cycles.
- The mult_start, mult_wb and mult_abort pulses are mutually exclusive and each lasts exactly one cycle.
- Reset asserted mid-MULT: outputs go to 0 immediately (asynchronously) and no mult_wb follows. After release the FSM is in IDLE.
- Counter wrap is not possible: the counter loads only in IDLE and MBUSY exits at 1.

## Structure
- Shared package/defines:
  - OP_* opcode codes.
  - EXE_* commands, including EXE_MULT and EXE_NO_OPERATION.
  - COND_* branch conditions.
  - FSM state encoding.
- Natural sub-module: `opcode_decoder`, a pure combinational opcode → control-bundle map. It carries illegal_op and is instantiated once. The FSM and gating stay in the top level.

## Test plan
- Reset, then ADD with instr_valid=1 → EXE_CMD=EXE_ADD and WB_EN=1 in the same cycle; stall_req=0; illegal_op=0.
- MULT at cycle 0 with MULT_CYCLES=4 → mult_start at cycle 0; stall_req=1 in cycles 0–3; mult_wb and WB_EN=1 at cycle 4; stall_req=0 at cycle 4; IDLE at cycle 5.
- MULT, then flush at cycle 2 → mult_abort at cycle 2; no mult_wb in cycles 3–6; next ADD decodes at cycle 3.
- hazard_detected=1 with LD → all outputs 0. Same with flush=1 and hazard=1 → all outputs 0, with no illegal_op.
- Unknown opcode with instr_valid=1 → illegal_op=1 and all control 0. With instr_valid=0 → illegal_op=0.
- rst low during MBUSY with counter=2 → all outputs 0 immediately. After release, ADD decodes normally and no mult_wb appears.
